// File: rtl/pixel_sink_pkg.sv
// Shared constants, state encoding and address helper for the pixel sink.
package pixel_sink_pkg;

    localparam int unsigned H_RES     = 320;
    localparam int unsigned V_RES     = 240;
    localparam int unsigned FB_WORDS  = 76800;
    localparam int unsigned FB_ADDR_W = 17;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StClear = 2'd2
    } state_e;

    // y*320 + x without a multiplier.
    function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        logic [FB_ADDR_W-1:0] yw;
        logic [FB_ADDR_W-1:0] xw;
        yw = FB_ADDR_W'(y);
        xw = FB_ADDR_W'(x);
        return (yw << 8) + (yw << 6) + xw;
    endfunction

endpackage

// File: rtl/pixel_sink_if.sv
// Pixel request, clear control and framebuffer write port of the pixel sink.
interface pixel_sink_if
    import pixel_sink_pkg::*;
#(
    parameter int unsigned COLOUR_W = 3
) ();

    logic [8:0]           x_position;
    logic [7:0]           y_position;
    logic [COLOUR_W-1:0]  colour;
    logic                 VGA_enable;
    logic                 ready;
    logic                 clear;
    logic [COLOUR_W-1:0]  clear_colour;
    logic                 busy;
    logic [FB_ADDR_W-1:0] mem_addr;
    logic [COLOUR_W-1:0]  mem_data;
    logic                 mem_we;
    logic                 mem_ready;
    logic [7:0]           drop_count;

    modport slave (
        input  x_position, y_position, colour, VGA_enable, clear, clear_colour, mem_ready,
        output ready, busy, mem_addr, mem_data, mem_we, drop_count
    );

    modport master (
        output x_position, y_position, colour, VGA_enable, clear, clear_colour, mem_ready,
        input  ready, busy, mem_addr, mem_data, mem_we, drop_count
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with registered full/empty/one flags and a combinational head read.
module pixel_fifo #(
    parameter int unsigned Width = 20,
    parameter int unsigned Depth = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             one
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             one_q, one_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
        full_d  = (count_d == (PtrW + 1)'(Depth));
        empty_d = (count_d == '0);
        one_d   = (count_d == (PtrW + 1)'(1));
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            one_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            one_q    <= one_d;
        end
    end

    // Storage needs no reset; the head is only used while empty is low.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign one   = one_q;

endmodule

// File: rtl/pixel_sink.sv
// Buffers pixel writes into a framebuffer port and performs full-frame clears.
module pixel_sink
    import pixel_sink_pkg::*;
#(
    parameter int unsigned COLOUR_W   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned H_RES      = 320,
    parameter int unsigned V_RES      = 240
) (
    input  logic         clock,
    input  logic         resetn,
    pixel_sink_if.slave  bus
);

    localparam int unsigned EntryW = FB_ADDR_W + COLOUR_W;
    localparam logic [FB_ADDR_W-1:0] SweepLast = FB_ADDR_W'(H_RES * V_RES - 1);

    state_e               state_q, state_d;
    logic                 alive_q;
    logic [FB_ADDR_W-1:0] sweep_q, sweep_d;
    logic [COLOUR_W-1:0]  fill_q, fill_d;
    logic [7:0]           drop_q, drop_d;

    logic                 fifo_full, fifo_empty, fifo_one;
    logic                 ready_w, accept, in_range, push, pop, mem_hs;
    logic [EntryW-1:0]    entry, head;
    logic [FB_ADDR_W-1:0] mem_addr_w;
    logic [COLOUR_W-1:0]  mem_data_w;
    logic                 mem_we_w;

    pixel_fifo #(
        .Width (EntryW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push),
        .wdata  (entry),
        .pop    (pop),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .one    (fifo_one)
    );

    // alive_q keeps ready low while reset is held and rises on the first edge after release.
    always_comb begin
        ready_w  = alive_q && (state_q == StRun) && !fifo_full;
        accept   = bus.VGA_enable && ready_w;
        in_range = (32'(bus.x_position) < H_RES) && (32'(bus.y_position) < V_RES);
        push     = accept && in_range;
        entry    = {pix_addr(bus.x_position, bus.y_position), bus.colour};

        if (state_q == StClear) begin
            mem_we_w   = 1'b1;
            mem_addr_w = sweep_q;
            mem_data_w = fill_q;
        end else begin
            mem_we_w   = !fifo_empty;
            mem_addr_w = fifo_empty ? '0 : head[EntryW-1:COLOUR_W];
            mem_data_w = fifo_empty ? '0 : head[COLOUR_W-1:0];
        end
        mem_hs = mem_we_w && bus.mem_ready;
        pop    = mem_hs && (state_q != StClear);
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        fill_d  = fill_q;
        drop_d  = drop_q;

        if (accept && !in_range && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StRun: begin
                if (bus.clear) begin
                    fill_d  = bus.clear_colour;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (fifo_empty || (pop && fifo_one)) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                if (mem_hs) begin
                    if (sweep_q == SweepLast) begin
                        sweep_d = '0;
                        state_d = StRun;
                    end else begin
                        sweep_d = sweep_q + FB_ADDR_W'(1);
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StRun;
            alive_q <= 1'b0;
            sweep_q <= '0;
            fill_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            sweep_q <= sweep_d;
            fill_q  <= fill_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.ready      = ready_w;
    assign bus.busy       = !fifo_empty || (state_q != StRun);
    assign bus.mem_we     = mem_we_w;
    assign bus.mem_addr   = mem_addr_w;
    assign bus.mem_data   = mem_data_w;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Randomized and directed bench for pixel_sink against a queue-based frame-write model.
module tb_pixel_sink;

    localparam int unsigned CW      = 3;
    localparam int unsigned Depth   = 4;
    localparam int          FbWords = 320 * 240;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clock  = 1'b0;
    logic resetn = 1'b1;

    pixel_sink_if #(.COLOUR_W(CW)) bus ();

    pixel_sink #(
        .COLOUR_W   (CW),
        .FIFO_DEPTH (Depth),
        .H_RES      (320),
        .V_RES      (240)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    wr_t exp_q[$];
    bit  m_clear;
    int  m_colour;
    int  m_sweep;
    int  m_drop;
    int  sweep_writes;
    bit  last_acc;
    int  n_checks;
    int  n_errors;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a falling edge: check outputs, advance the model, step one clock.
    task automatic tick();
        bit  m_ready;
        wr_t w;
        int  x, y;
        m_ready = !m_clear && (exp_q.size() < Depth);
        check_eq("ready", bus.ready, m_ready);
        check_eq("busy", bus.busy, m_clear || (exp_q.size() > 0));
        if (!m_clear) check_eq("mem_we", bus.mem_we, exp_q.size() > 0);
        check_eq("drop_count", bus.drop_count, m_drop);

        if (bus.mem_we && bus.mem_ready) begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_eq("pix_addr", bus.mem_addr, w.addr);
                check_eq("pix_data", bus.mem_data, w.data);
            end else if (m_clear) begin
                check_eq("sweep_addr", bus.mem_addr, m_sweep);
                check_eq("sweep_data", bus.mem_data, m_colour);
                m_sweep++;
                sweep_writes++;
                if (m_sweep == FbWords) begin
                    m_clear = 1'b0;
                    m_sweep = 0;
                end
            end else begin
                check_eq("spurious_write", bus.mem_we, 0);
            end
        end

        last_acc = bus.VGA_enable && m_ready;
        if (last_acc) begin
            x = int'(bus.x_position);
            y = int'(bus.y_position);
            if (x < 320 && y < 240) exp_q.push_back('{addr: y * 320 + x, data: int'(bus.colour)});
            else if (m_drop < 255) m_drop++;
        end
        if (m_ready && bus.clear) begin
            m_clear  = 1'b1;
            m_colour = int'(bus.clear_colour);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        bus.VGA_enable   = 1'b0;
        bus.clear        = 1'b0;
        bus.x_position   = '0;
        bus.y_position   = '0;
        bus.colour       = '0;
        bus.clear_colour = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check_eq("rst_ready", bus.ready, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_mem_we", bus.mem_we, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_mem_data", bus.mem_data, 0);
        check_eq("rst_drop", bus.drop_count, 0);
        exp_q.delete();
        m_clear = 1'b0;
        m_sweep = 0;
        m_drop  = 0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check_eq("ready_before_edge", bus.ready, 0);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_pixel(input int x, input int y, input int c);
        bus.x_position = 9'(x);
        bus.y_position = 8'(y);
        bus.colour     = CW'(c);
    endtask

    initial begin
        int  acc_cnt;
        int  nxt;
        bit  pulsed;
        n_checks     = 0;
        n_errors     = 0;
        sweep_writes = 0;
        idle_inputs();
        bus.mem_ready = 1'b1;
        #1;
        do_reset();

        // Single write: visible on the very next cycle.
        set_pixel(5, 2, 5);
        bus.VGA_enable = 1'b1;
        tick();
        bus.VGA_enable = 1'b0;
        check_eq("single_we", bus.mem_we, 1);
        check_eq("single_addr", bus.mem_addr, 645);
        check_eq("single_data", bus.mem_data, 5);
        tick();
        check_eq("single_we_off", bus.mem_we, 0);
        tick();

        // Back-pressure: five requests with memory stalled.
        bus.mem_ready  = 1'b0;
        acc_cnt        = 0;
        nxt            = 0;
        bus.VGA_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_pixel(10 + nxt, 7, nxt);
            tick();
            if (last_acc) begin
                acc_cnt++;
                nxt++;
            end
        end
        check_eq("bp_accepted", acc_cnt, 4);
        check_eq("bp_ready_low", bus.ready, 0);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 30 && (nxt < 5 || exp_q.size() > 0); i++) begin
            bus.VGA_enable = (nxt < 5);
            set_pixel(10 + nxt, 7, nxt);
            tick();
            if (last_acc) nxt++;
        end
        bus.VGA_enable = 1'b0;
        check_eq("bp_all_issued", nxt, 5);
        tick();

        // Out-of-range requests.
        bus.VGA_enable = 1'b1;
        set_pixel(320, 0, 1);   tick();
        set_pixel(0, 240, 1);   tick();
        set_pixel(511, 255, 1); tick();
        bus.VGA_enable = 1'b0;
        tick();
        check_eq("drop_three", bus.drop_count, 3);
        bus.VGA_enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) set_pixel($urandom_range(320, 511), $urandom_range(0, 255), 0);
            else                           set_pixel($urandom_range(0, 511), $urandom_range(240, 255), 0);
            tick();
        end
        bus.VGA_enable = 1'b0;
        tick();
        check_eq("drop_sat", bus.drop_count, 255);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.VGA_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) set_pixel($urandom_range(0, 511), $urandom_range(0, 255), $urandom);
            else                           set_pixel($urandom_range(0, 319), $urandom_range(0, 239), $urandom);
            bus.mem_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.VGA_enable = 1'b0;
        bus.mem_ready  = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tick();
        check_eq("rand_idle", bus.busy, 0);

        // Clear behind two queued pixels, with a second clear pulse mid-sweep.
        bus.mem_ready  = 1'b0;
        bus.VGA_enable = 1'b1;
        set_pixel(100, 50, 6); tick();
        set_pixel(7, 200, 3);  tick();
        bus.VGA_enable   = 1'b0;
        bus.clear        = 1'b1;
        bus.clear_colour = 3'b010;
        tick();
        bus.clear     = 1'b0;
        bus.mem_ready = 1'b1;
        sweep_writes  = 0;
        pulsed        = 1'b0;
        for (int i = 0; i < 90000 && m_clear; i++) begin
            if (m_sweep == 1000 && !pulsed) begin
                bus.clear        = 1'b1;
                bus.clear_colour = 3'b111;
                pulsed           = 1'b1;
            end else begin
                bus.clear = 1'b0;
            end
            bus.mem_ready = (m_sweep >= 2000) || ($urandom_range(0, 7) != 0);
            tick();
        end
        bus.clear     = 1'b0;
        bus.mem_ready = 1'b1;
        check_eq("clear_finished", m_clear, 0);
        check_eq("sweep_writes", sweep_writes, FbWords);
        check_eq("post_clear_busy", bus.busy, 0);
        check_eq("post_clear_ready", bus.ready, 1);
        tick();

        // Reset in the middle of a sweep.
        bus.clear        = 1'b1;
        bus.clear_colour = 3'b101;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 2000 && m_sweep != 500; i++) tick();
        check_eq("sweep_reached_500", bus.mem_addr, 500);
        do_reset();
        set_pixel(319, 239, 4);
        bus.VGA_enable = 1'b1;
        tick();
        bus.VGA_enable = 1'b0;
        check_eq("last_pixel_addr", bus.mem_addr, 76799);
        check_eq("last_pixel_data", bus.mem_data, 4);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pixel_sink.md
PIXEL_SINK -- requirements
Module: pixel_sink

Interface
REQ-001 Parameter COLOUR_W, default 3, colour width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, pixel request buffer entries (power of two).
REQ-003 Parameters H_RES = 320, V_RES = 240, drawable frame size.
REQ-004 clock  in  1  single clock, rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 x_position  in  9  pixel column of write request.
REQ-007 y_position  in  8  pixel row of write request.
REQ-008 colour  in  COLOUR_W  pixel data of write request.
REQ-009 VGA_enable  in  1  write request valid.
REQ-010 ready  out  1  request accepted on any cycle with VGA_enable and ready both high.
REQ-011 clear  in  1  start full-frame clear, sampled when high.
REQ-012 clear_colour  in  COLOUR_W  fill colour, captured on the cycle clear is accepted.
REQ-013 busy  out  1  FIFO non-empty or clear in progress.
REQ-014 mem_addr  out  17  framebuffer word address.
REQ-015 mem_data  out  COLOUR_W  framebuffer write data.
REQ-016 mem_we  out  1  framebuffer write strobe.
REQ-017 mem_ready  in  1  memory takes the write on a cycle with mem_we and mem_ready high.
REQ-018 drop_count  out  8  count of discarded out-of-range requests, saturating.

Function
REQ-019 States: RUN, DRAIN, CLEAR; RUN after reset.
REQ-020 ready = (state == RUN) and FIFO not full, from registered state only; no combinational path from VGA_enable or mem_ready.
REQ-021 Accepted request with x_position >= 320 or y_position >= 240: not queued; drop_count +1, holding at 255.
REQ-022 In-range accepted request: pushed as {addr = y*320 + x, colour}, address formed as (y<<8)+(y<<6)+x at 17 bits.
REQ-023 Latency: request accepted at cycle N into an empty FIFO drives mem_we high with its addr/data at cycle N+1.
REQ-024 Memory port: mem_addr, mem_data, mem_we held stable until mem_ready; entry popped on handshake; next entry may present the following cycle (one write per cycle at full throughput).
REQ-025 Simultaneous push and pop in the same cycle: both take effect; occupancy unchanged; FIFO order strictly preserved.
REQ-026 clear in RUN: clear_colour latched, go to DRAIN; ready low from next cycle.
REQ-027 DRAIN: FIFO emptied through memory port; enter CLEAR the cycle after last pop (immediately if already empty).
REQ-028 CLEAR: sweep counter 0..76799, mem_we high, mem_data = latched colour; counter advances only on mem_ready; after handshake at 76799 return to RUN.
REQ-029 clear asserted in DRAIN or CLEAR: ignored; sweep not restarted.
REQ-030 VGA_enable high while ready low: no effect, not counted as drop.
REQ-031 busy = FIFO non-empty or state != RUN.
REQ-032 mem_we low whenever FIFO empty in RUN/DRAIN.

Reset
REQ-033 resetn low: state RUN, FIFO empty, sweep counter 0, drop_count 0, latched colour 0, mem_we 0, mem_addr 0, mem_data 0, busy 0, ready 0.
REQ-034 Reset mid-clear or mid-write: pending entries and sweep abandoned; ready 1 on first clock edge after resetn rises.

Structure
REQ-035 Shared package holds H_RES, V_RES, FB_WORDS = 76800, FB_ADDR_W = 17, state encoding.
REQ-036 FIFO is one sub-module, pixel_fifo (sync, width 17+COLOUR_W, registered full/empty).

Verification
REQ-037 Single write (x=5, y=2, colour=3'b101), mem_ready=1 -> mem_we one cycle at N+1, mem_addr=645, mem_data=5.
REQ-038 mem_ready=0, 5 back-to-back requests -> ready low after 4 accepted; release mem_ready -> addresses written in issue order, none lost.
REQ-039 Requests (320,0), (0,240), (511,255) -> no mem_we, drop_count=3; 300 bad requests -> drop_count=255.
REQ-040 Two queued pixels then clear with clear_colour=3'b010 -> both pixels written first, then addrs 0..76799 with data 2, busy low after last, ready high.
REQ-041 clear pulsed again at sweep addr 1000 -> sweep continues to 76799, no restart.
REQ-042 resetn low at sweep addr 500 -> all outputs 0 immediately; after release, write (319,239) -> mem_addr=76799.
